regfile_scoreboard: RTL and testbench

- Receiving end of the writeback interface: consumes wb_regno / wb_data / do_wb from the writeback stage and commits them to the architectural register file.
- Serves two combinational read ports to the decode/issue stage, with same-cycle bypass of the incoming writeback.
- Keeps a one-bit-per-register scoreboard of in-flight writes and raises issue_stall on RAW/WAW hazards, so issue never reads stale data or allows two outstanding writes to one register.

---
 rtl/regfile_scoreboard_pkg.sv | 8 +
 rtl/regfile_scoreboard_scoreboard.sv | 56 +++++
 rtl/regfile_scoreboard.sv | 81 ++++++++
 tb/tb_regfile_scoreboard.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing for the register file / scoreboard slice.
package regfile_scoreboard_pkg;

   localparam int DEF_LEN_REG   = 32;
   localparam int DEF_LEN_REGNO = 4;
   localparam int DEF_NUM_REGS  = 1 << DEF_LEN_REGNO;

endpackage

// File: rtl/regfile_scoreboard_scoreboard.sv
// One pending-write bit per register; a same-cycle writeback masks the hazard.
module regfile_scoreboard_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int LEN_REGNO = DEF_LEN_REGNO
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 do_wb,
   input  logic [LEN_REGNO-1:0] wb_regno,
   input  logic                 set_en,
   input  logic [LEN_REGNO-1:0] set_regno,
   input  logic [LEN_REGNO-1:0] rs1_regno,
   input  logic [LEN_REGNO-1:0] rs2_regno,
   input  logic [LEN_REGNO-1:0] rd_regno,
   output logic                 pend_rs1,
   output logic                 pend_rs2,
   output logic                 pend_rd
);

   localparam int NUM_REGS = 1 << LEN_REGNO;

   logic [NUM_REGS-1:0] sb_q;
   logic [NUM_REGS-1:0] sb_d;
   logic [NUM_REGS-1:0] wb_mask;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] pend;

   always_comb begin
      wb_mask  = '0;
      set_mask = '0;
      if (do_wb)
         wb_mask[wb_regno] = 1'b1;
      if (set_en)
         set_mask[set_regno] = 1'b1;
      pend = sb_q & ~wb_mask;
      // Set is OR-ed after the clear so a new issue survives the old write completing.
      if (flush)
         sb_d = '0;
      else
         sb_d = pend | set_mask;
   end

   assign pend_rs1 = pend[rs1_regno];
   assign pend_rs2 = pend[rs2_regno];
   assign pend_rd  = pend[rd_regno];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sb_q <= '0;
      else
         sb_q <= sb_d;
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with writeback bypass and RAW/WAW issue interlock.
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int LEN_REG   = DEF_LEN_REG,
   parameter int LEN_REGNO = DEF_LEN_REGNO
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_valid,
   input  logic                 issue_is_wb,
   input  logic [LEN_REGNO-1:0] issue_rd,
   input  logic [LEN_REGNO-1:0] rs1_regno,
   input  logic [LEN_REGNO-1:0] rs2_regno,
   input  logic                 rs1_use,
   input  logic                 rs2_use,
   input  logic                 stall_i,
   input  logic                 flush,
   input  logic [LEN_REGNO-1:0] wb_regno,
   input  logic [LEN_REG-1:0]   wb_data,
   input  logic                 do_wb,
   output logic [LEN_REG-1:0]   rs1_data,
   output logic [LEN_REG-1:0]   rs2_data,
   output logic                 issue_stall,
   output logic                 issue_fire
);

   localparam int NUM_REGS = 1 << LEN_REGNO;

   logic [LEN_REG-1:0] regs_q [NUM_REGS];
   logic [LEN_REG-1:0] regs_d [NUM_REGS];
   logic               pend_rs1;
   logic               pend_rs2;
   logic               pend_rd;

   always_comb begin
      regs_d = regs_q;
      if (do_wb)
         regs_d[wb_regno] = wb_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         regs_q <= '{default: '0};
      else
         regs_q <= regs_d;
   end

   always_comb begin
      rs1_data = regs_q[rs1_regno];
      rs2_data = regs_q[rs2_regno];
      if (do_wb && (wb_regno == rs1_regno))
         rs1_data = wb_data;
      if (do_wb && (wb_regno == rs2_regno))
         rs2_data = wb_data;
   end

   assign issue_stall = issue_valid && ((rs1_use && pend_rs1) ||
                                        (rs2_use && pend_rs2) ||
                                        (issue_is_wb && pend_rd));
   assign issue_fire  = issue_valid && !issue_stall && !stall_i;

   regfile_scoreboard_scoreboard #(
      .LEN_REGNO (LEN_REGNO)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .do_wb     (do_wb),
      .wb_regno  (wb_regno),
      .set_en    (issue_fire && issue_is_wb),
      .set_regno (issue_rd),
      .rs1_regno (rs1_regno),
      .rs2_regno (rs2_regno),
      .rd_regno  (issue_rd),
      .pend_rs1  (pend_rs1),
      .pend_rs2  (pend_rs2),
      .pend_rd   (pend_rd)
   );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, RAW/WAW interlock, flush, async reset.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic        issue_is_wb;
   logic [3:0]  issue_rd;
   logic [3:0]  rs1_regno;
   logic [3:0]  rs2_regno;
   logic        rs1_use;
   logic        rs2_use;
   logic        stall_i;
   logic        flush;
   logic [3:0]  wb_regno;
   logic [31:0] wb_data;
   logic        do_wb;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        issue_stall;
   logic        issue_fire;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_scoreboard #(
      .LEN_REG   (32),
      .LEN_REGNO (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_is_wb (issue_is_wb),
      .issue_rd    (issue_rd),
      .rs1_regno   (rs1_regno),
      .rs2_regno   (rs2_regno),
      .rs1_use     (rs1_use),
      .rs2_use     (rs2_use),
      .stall_i     (stall_i),
      .flush       (flush),
      .wb_regno    (wb_regno),
      .wb_data     (wb_data),
      .do_wb       (do_wb),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .issue_stall (issue_stall),
      .issue_fire  (issue_fire)
   );

   task automatic idle();
      issue_valid = 1'b0; issue_is_wb = 1'b0; issue_rd = 4'd0;
      rs1_regno = 4'd0; rs2_regno = 4'd0; rs1_use = 1'b0; rs2_use = 1'b0;
      stall_i = 1'b0; flush = 1'b0; wb_regno = 4'd0; wb_data = '0; do_wb = 1'b0;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled at +2.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0;
      #2;
      for (int i = 0; i < 16; i++) begin
         rs1_regno = 4'(i);
         rs2_regno = 4'(15 - i);
         rs1_use = 1'b1; rs2_use = 1'b1;
         issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'(i);
         #1;
         checks++;
         if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_read r%0d got %h/%h exp 0/0", i, rs1_data, rs2_data);
         end
         checks++;
         if (issue_stall !== 1'b0 || issue_fire !== 1'b1) begin
            errors++;
            $display("FAIL reset_issue r%0d stall/fire got %b%b exp 01", i, issue_stall, issue_fire);
         end
      end
      stall_i = 1'b1;
      #1;
      checks++;
      if (issue_fire !== 1'b0) begin
         errors++;
         $display("FAIL reset_fire_stall_i got %b exp 0", issue_fire);
      end
      idle();
      #1;
      checks++;
      if (issue_fire !== 1'b0) begin
         errors++;
         $display("FAIL reset_fire_novalid got %b exp 0", issue_fire);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_raw();
      issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'd3;
      #1;
      checks++;
      if (issue_fire !== 1'b1) begin
         errors++;
         $display("FAIL raw_issue_rd3 fire got %b exp 1", issue_fire);
      end
      tick();
      issue_valid = 1'b1; rs1_regno = 4'd3; rs1_use = 1'b1;
      #1;
      checks++;
      if (issue_stall !== 1'b1 || issue_fire !== 1'b0) begin
         errors++;
         $display("FAIL raw_stall stall/fire got %b%b exp 10", issue_stall, issue_fire);
      end
      do_wb = 1'b1; wb_regno = 4'd3; wb_data = 32'hDEADBEEF;
      #1;
      checks++;
      if (issue_stall !== 1'b0 || issue_fire !== 1'b1) begin
         errors++;
         $display("FAIL raw_wb_release stall/fire got %b%b exp 01", issue_stall, issue_fire);
      end
      checks++;
      if (rs1_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL raw_bypass got %h exp deadbeef", rs1_data);
      end
      tick();
      issue_valid = 1'b1; rs1_regno = 4'd3; rs1_use = 1'b1; rs2_regno = 4'd3;
      #1;
      checks++;
      if (rs1_data !== 32'hDEADBEEF || rs2_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL raw_reg_read got %h/%h exp deadbeef", rs1_data, rs2_data);
      end
      checks++;
      if (issue_stall !== 1'b0) begin
         errors++;
         $display("FAIL raw_sb_cleared stall got %b exp 0", issue_stall);
      end
      tick();
   endtask

   task automatic test_waw();
      issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'd5;
      tick();
      issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'd5;
      #1;
      checks++;
      if (issue_stall !== 1'b1) begin
         errors++;
         $display("FAIL waw_stall got %b exp 1", issue_stall);
      end
      do_wb = 1'b1; wb_regno = 4'd5; wb_data = 32'h0000000A;
      #1;
      checks++;
      if (issue_stall !== 1'b0 || issue_fire !== 1'b1) begin
         errors++;
         $display("FAIL waw_reissue stall/fire got %b%b exp 01", issue_stall, issue_fire);
      end
      tick();
      issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'd5; rs2_regno = 4'd5;
      #1;
      checks++;
      if (issue_stall !== 1'b1) begin
         errors++;
         $display("FAIL waw_set_wins stall got %b exp 1", issue_stall);
      end
      checks++;
      if (rs2_data !== 32'h0000000A) begin
         errors++;
         $display("FAIL waw_data got %h exp 0000000a", rs2_data);
      end
      idle();
      do_wb = 1'b1; wb_regno = 4'd5; wb_data = 32'h0000000B;
      tick();
      issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'd5;
      #1;
      checks++;
      if (issue_stall !== 1'b0) begin
         errors++;
         $display("FAIL waw_cleared stall got %b exp 0", issue_stall);
      end
      idle();
      tick();
   endtask

   task automatic test_stall_i();
      issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'd7; stall_i = 1'b1;
      #1;
      checks++;
      if (issue_stall !== 1'b0 || issue_fire !== 1'b0) begin
         errors++;
         $display("FAIL stalli_block stall/fire got %b%b exp 00", issue_stall, issue_fire);
      end
      tick();
      issue_valid = 1'b1; rs1_regno = 4'd7; rs1_use = 1'b1;
      #1;
      checks++;
      if (issue_stall !== 1'b0) begin
         errors++;
         $display("FAIL stalli_no_set stall got %b exp 0", issue_stall);
      end
      idle();
      issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'd7;
      #1;
      checks++;
      if (issue_fire !== 1'b1) begin
         errors++;
         $display("FAIL stalli_release fire got %b exp 1", issue_fire);
      end
      tick();
      issue_valid = 1'b1; rs1_regno = 4'd7; rs1_use = 1'b1; stall_i = 1'b1;
      #1;
      checks++;
      if (issue_stall !== 1'b1 || issue_fire !== 1'b0) begin
         errors++;
         $display("FAIL stalli_set_independent stall/fire got %b%b exp 10", issue_stall, issue_fire);
      end
      idle();
      do_wb = 1'b1; wb_regno = 4'd7; wb_data = 32'h7;
      tick();
   endtask

   task automatic test_flush();
      issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'd2;
      tick();
      issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'd9;
      tick();
      issue_valid = 1'b1; rs1_regno = 4'd2; rs1_use = 1'b1;
      #1;
      checks++;
      if (issue_stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_pre_r2 stall got %b exp 1", issue_stall);
      end
      idle();
      issue_valid = 1'b1; rs2_regno = 4'd9; rs2_use = 1'b1;
      #1;
      checks++;
      if (issue_stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_pre_r9 stall got %b exp 1", issue_stall);
      end
      idle();
      flush = 1'b1; do_wb = 1'b1; wb_regno = 4'd9; wb_data = 32'h55;
      issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'd11;
      tick();
      issue_valid = 1'b1; rs1_regno = 4'd2; rs1_use = 1'b1; rs2_regno = 4'd9; rs2_use = 1'b1;
      #1;
      checks++;
      if (issue_stall !== 1'b0) begin
         errors++;
         $display("FAIL flush_cleared stall got %b exp 0", issue_stall);
      end
      checks++;
      if (rs2_data !== 32'h55) begin
         errors++;
         $display("FAIL flush_wb_r9 got %h exp 00000055", rs2_data);
      end
      idle();
      issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'd11;
      #1;
      checks++;
      if (issue_stall !== 1'b0) begin
         errors++;
         $display("FAIL flush_set_suppressed stall got %b exp 0", issue_stall);
      end
      idle();
      tick();
   endtask

   task automatic test_back_to_back();
      do_wb = 1'b1; wb_regno = 4'd1; wb_data = 32'h11; rs1_regno = 4'd1; rs2_regno = 4'd2;
      #1;
      checks++;
      if (rs1_data !== 32'h11 || rs2_data !== 32'h0) begin
         errors++;
         $display("FAIL b2b_first got %h/%h exp 00000011/00000000", rs1_data, rs2_data);
      end
      tick();
      do_wb = 1'b1; wb_regno = 4'd2; wb_data = 32'h22; rs1_regno = 4'd1; rs2_regno = 4'd2;
      #1;
      checks++;
      if (rs1_data !== 32'h11 || rs2_data !== 32'h22) begin
         errors++;
         $display("FAIL b2b_second got %h/%h exp 00000011/00000022", rs1_data, rs2_data);
      end
      tick();
      do_wb = 1'b1; wb_regno = 4'd1; wb_data = 32'h99; rs1_regno = 4'd1; rs2_regno = 4'd2;
      #1;
      checks++;
      if (rs1_data !== 32'h99 || rs2_data !== 32'h22) begin
         errors++;
         $display("FAIL b2b_bypass_priority got %h/%h exp 00000099/00000022", rs1_data, rs2_data);
      end
      tick();
      rs1_regno = 4'd1;
      #1;
      checks++;
      if (rs1_data !== 32'h99) begin
         errors++;
         $display("FAIL b2b_final got %h exp 00000099", rs1_data);
      end
   endtask

   task automatic test_async_reset();
      do_wb = 1'b1; wb_regno = 4'd4; wb_data = 32'h1234;
      issue_valid = 1'b1; issue_is_wb = 1'b1; issue_rd = 4'd4;
      tick();
      issue_valid = 1'b1; rs1_regno = 4'd4; rs1_use = 1'b1;
      #1;
      checks++;
      if (rs1_data !== 32'h1234 || issue_stall !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre data/stall got %h/%b exp 00001234/1", rs1_data, issue_stall);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (rs1_data !== 32'h0 || issue_stall !== 1'b0) begin
         errors++;
         $display("FAIL arst_immediate data/stall got %h/%b exp 00000000/0", rs1_data, issue_stall);
      end
      idle();
      #1;
      rst = 1'b1;
      tick();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_raw();
      test_waw();
      test_stall_i();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
